// File: rtl/fixed_encoder_multi_order.sv
// fixed_encoder_multi_order
//   FLAC fixed-polynomial residual encoder, predictor order 0..4 selected per
//   frame. Warm-up samples (the first <order> samples of a frame) are passed
//   through verbatim. All other samples produce the full-precision order-N
//   residual. Latency is 3 clocks after acceptance, at one sample per clock.
//
// Ports
//   iClock       rising-edge clock
//   iReset       synchronous active-high reset
//   iEnable      sample strobe; iSample accepted when high
//   iFrameStart  accepted sample starts a new frame (latches iOrder)
//   iOrder       predictor order for the new frame; 5..7 treated as 4
//   iSample      signed input sample
//   oData        residual, or sign-extended warm-up sample
//   oValid       oData/oWarmup/oOrder hold the result for one sample
//   oWarmup      oData is a verbatim warm-up sample
//   oOrder       order applied to the sample on oData

module fixed_encoder_multi_order #(
   parameter int SAMPLE_WIDTH   = 16,
   parameter int RESIDUAL_WIDTH = SAMPLE_WIDTH + 4
) (
   input  logic                             iClock,
   input  logic                             iReset,
   input  logic                             iEnable,
   input  logic                             iFrameStart,
   input  logic [2:0]                       iOrder,
   input  logic signed [SAMPLE_WIDTH-1:0]   iSample,
   output logic signed [RESIDUAL_WIDTH-1:0] oData,
   output logic                             oValid,
   output logic                             oWarmup,
   output logic [2:0]                       oOrder
);

   localparam int SW = SAMPLE_WIDTH;
   localparam int RW = RESIDUAL_WIDTH;
   localparam logic [2:0] MAX_ORDER = 3'd4;

   function automatic logic signed [RW-1:0] sext(input logic signed [SW-1:0] v);
      return {{(RW-SW){v[SW-1]}}, v};
   endfunction

   // ---------------------------------------------------------------------
   // Frame order / warm-up bookkeeping for the sample being accepted now.
   // A frame start takes effect on its own sample, so the effective order
   // and counter are muxed before the registered values are updated.
   // ---------------------------------------------------------------------
   logic [2:0] frame_order;
   logic [2:0] warm_cnt;
   logic [2:0] order_in;
   logic [2:0] cur_order;
   logic [2:0] cur_cnt;
   logic [2:0] cnt_next;
   logic       cur_warm;

   always_comb begin
      order_in  = (iOrder > MAX_ORDER) ? MAX_ORDER : iOrder;
      cur_order = iFrameStart ? order_in : frame_order;
      cur_cnt   = iFrameStart ? 3'd0 : warm_cnt;
      cur_warm  = (cur_cnt < cur_order);
      cnt_next  = (cur_cnt >= MAX_ORDER) ? MAX_ORDER : cur_cnt + 3'd1;
   end

   // ---------------------------------------------------------------------
   // S1: sample, flags and history taps (taps are the history *before*
   // this sample). History shifts only on accepted samples.
   // ---------------------------------------------------------------------
   logic signed [SW-1:0] h1, h2, h3, h4;
   logic                 s1_valid;
   logic                 s1_warm;
   logic [2:0]           s1_order;
   logic signed [SW-1:0] s1_x, s1_x1, s1_x2, s1_x3, s1_x4;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         frame_order <= '0;
         warm_cnt    <= MAX_ORDER;
         h1          <= '0;
         h2          <= '0;
         h3          <= '0;
         h4          <= '0;
         s1_valid    <= 1'b0;
         s1_warm     <= 1'b0;
         s1_order    <= '0;
         s1_x        <= '0;
         s1_x1       <= '0;
         s1_x2       <= '0;
         s1_x3       <= '0;
         s1_x4       <= '0;
      end else begin
         s1_valid <= iEnable;
         if (iEnable) begin
            frame_order <= cur_order;
            warm_cnt    <= cnt_next;
            s1_warm     <= cur_warm;
            s1_order    <= cur_order;
            s1_x        <= iSample;
            s1_x1       <= h1;
            s1_x2       <= h2;
            s1_x3       <= h3;
            s1_x4       <= h4;
            h1          <= iSample;
            h2          <= h1;
            h3          <= h2;
            h4          <= h3;
         end
      end
   end

   // ---------------------------------------------------------------------
   // S2: coefficient-scaled taps. Magnitudes only; the alternating signs
   // of the binomial coefficients are applied when summing in S3.
   // ---------------------------------------------------------------------
   logic signed [RW-1:0] e1, e2, e3, e4;
   logic signed [RW-1:0] t1_n, t2_n, t3_n, t4_n;

   always_comb begin
      e1   = sext(s1_x1);
      e2   = sext(s1_x2);
      e3   = sext(s1_x3);
      e4   = sext(s1_x4);
      t1_n = '0;
      t2_n = '0;
      t3_n = '0;
      t4_n = '0;
      case (s1_order)
         3'd1: begin
            t1_n = e1;
         end
         3'd2: begin
            t1_n = e1 <<< 1;
            t2_n = e2;
         end
         3'd3: begin
            t1_n = (e1 <<< 1) + e1;
            t2_n = (e2 <<< 1) + e2;
            t3_n = e3;
         end
         3'd4: begin
            t1_n = e1 <<< 2;
            t2_n = (e2 <<< 2) + (e2 <<< 1);
            t3_n = e3 <<< 2;
            t4_n = e4;
         end
         default: begin
         end
      endcase
   end

   logic                 s2_valid;
   logic                 s2_warm;
   logic [2:0]           s2_order;
   logic signed [RW-1:0] s2_t0, s2_t1, s2_t2, s2_t3, s2_t4;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         s2_valid <= 1'b0;
         s2_warm  <= 1'b0;
         s2_order <= '0;
         s2_t0    <= '0;
         s2_t1    <= '0;
         s2_t2    <= '0;
         s2_t3    <= '0;
         s2_t4    <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_warm  <= s1_warm;
         s2_order <= s1_order;
         s2_t0    <= sext(s1_x);
         s2_t1    <= t1_n;
         s2_t2    <= t2_n;
         s2_t3    <= t3_n;
         s2_t4    <= t4_n;
      end
   end

   // ---------------------------------------------------------------------
   // S3: two signed partial sums. Every intermediate stays within the
   // residual range, so no extra guard bits are needed.
   // ---------------------------------------------------------------------
   logic                 s3_valid;
   logic                 s3_warm;
   logic [2:0]           s3_order;
   logic signed [RW-1:0] s3_x, s3_p0, s3_p1;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         s3_valid <= 1'b0;
         s3_warm  <= 1'b0;
         s3_order <= '0;
         s3_x     <= '0;
         s3_p0    <= '0;
         s3_p1    <= '0;
      end else begin
         s3_valid <= s2_valid;
         s3_warm  <= s2_warm;
         s3_order <= s2_order;
         s3_x     <= s2_t0;
         s3_p0    <= s2_t0 - s2_t1;
         s3_p1    <= s2_t2 - s2_t3 + s2_t4;
      end
   end

   // Final sum and warm-up mux into the output register; data outputs
   // hold their last value across bubbles.
   always_ff @(posedge iClock) begin
      if (iReset) begin
         oValid  <= 1'b0;
         oData   <= '0;
         oWarmup <= 1'b0;
         oOrder  <= '0;
      end else begin
         oValid <= s3_valid;
         if (s3_valid) begin
            oData   <= s3_warm ? s3_x : (s3_p0 + s3_p1);
            oWarmup <= s3_warm;
            oOrder  <= s3_order;
         end
      end
   end

endmodule

// File: tb/tb_fixed_encoder_multi_order.sv
// Directed + random bench for fixed_encoder_multi_order. Expected results are
// pushed to a scoreboard queue as samples are driven; a negedge monitor pops
// and compares them (data, warm-up flag, order, arrival cycle).

module tb_fixed_encoder_multi_order;

   localparam int SW = 16;
   localparam int RW = SW + 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 en;
   logic                 fs;
   logic [2:0]           ord;
   logic signed [SW-1:0] smp;
   logic signed [RW-1:0] data;
   logic                 valid;
   logic                 warm;
   logic [2:0]           oord;

   always #5 clk = ~clk;

   fixed_encoder_multi_order #(
      .SAMPLE_WIDTH  (SW),
      .RESIDUAL_WIDTH(RW)
   ) dut (
      .iClock     (clk),
      .iReset     (reset),
      .iEnable    (en),
      .iFrameStart(fs),
      .iOrder     (ord),
      .iSample    (smp),
      .oData      (data),
      .oValid     (valid),
      .oWarmup    (warm),
      .oOrder     (oord)
   );

   typedef struct {
      logic signed [RW-1:0] data;
      logic                 warm;
      logic [2:0]           order;
      int unsigned          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Reference model state
   int     m_order;
   int     m_cnt;
   longint m_h1, m_h2, m_h3, m_h4;

   task automatic model_reset();
      m_order = 0;
      m_cnt   = 4;
      m_h1 = 0; m_h2 = 0; m_h3 = 0; m_h4 = 0;
   endtask

   // Drive one accepted sample on the next negedge and compute its expectation.
   task automatic drive(input int x, input bit f, input int o, output exp_t m);
      longint r;
      longint xl;
      @(negedge clk);
      en  = 1'b1;
      fs  = f;
      ord = 3'(o);
      smp = SW'(x);
      xl  = longint'(x);
      if (f) begin
         m_order = (o > 4) ? 4 : o;
         m_cnt   = 0;
      end
      case (m_order)
         1:       r = xl - m_h1;
         2:       r = xl - 2 * m_h1 + m_h2;
         3:       r = xl - 3 * m_h1 + 3 * m_h2 - m_h3;
         4:       r = xl - 4 * m_h1 + 6 * m_h2 - 4 * m_h3 + m_h4;
         default: r = xl;
      endcase
      m.warm = (m_cnt < m_order);
      if (m.warm) r = xl;
      m.data  = RW'(r);
      m.order = 3'(m_order);
      m.cyc   = cyc + 4;
      m_cnt   = (m_cnt >= 4) ? 4 : m_cnt + 1;
      m_h4 = m_h3; m_h3 = m_h2; m_h2 = m_h1; m_h1 = xl;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en = 1'b0;
         fs = 1'b0;
      end
   endtask

   // Directed sample: expected values given explicitly (only arrival cycle from drive).
   task automatic send_exp(input int x, input bit f, input int o, input longint ed,
                           input bit ew, input int eo, input int gap);
      exp_t m;
      drive(x, f, o, m);
      m.data  = RW'(ed);
      m.warm  = ew;
      m.order = 3'(eo);
      sb.push_back(m);
      idle(gap);
   endtask

   task automatic send_model(input int x, input bit f, input int o, input int gap);
      exp_t m;
      drive(x, f, o, m);
      sb.push_back(m);
      idle(gap);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b0;
      fs    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic drain();
      idle(1);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("drain_empty", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("data", data, mon_e.data);
            check("warmup", warm, mon_e.warm);
            check("order", oord, mon_e.order);
            check("arrival_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t dropped;
      reset = 1'b0;
      en    = 1'b0;
      fs    = 1'b0;
      ord   = '0;
      smp   = '0;
      model_reset();

      do_reset();
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_warm", warm, 0);
      check("rst_order", oord, 0);

      // Order 2, contiguous
      send_exp(10, 1, 2, 10, 1, 2, 0);
      send_exp(20, 0, 2, 20, 1, 2, 0);
      send_exp(40, 0, 2, 10, 0, 2, 0);
      send_exp(70, 0, 2, 10, 0, 2, 0);
      drain();

      // Order 4 extremes: worst-case growth without wrap
      send_exp( 32767, 1, 4,  32767, 1, 4, 0);
      send_exp(-32768, 0, 4, -32768, 1, 4, 0);
      send_exp( 32767, 0, 4,  32767, 1, 4, 0);
      send_exp(-32768, 0, 4, -32768, 1, 4, 0);
      send_exp( 32767, 0, 4, 524280, 0, 4, 0);
      drain();

      // Order 1 with two-clock bubbles
      send_exp(5, 1, 1,  5, 1, 1, 2);
      send_exp(8, 0, 1,  3, 0, 1, 2);
      send_exp(4, 0, 1, -4, 0, 1, 2);
      drain();

      // Mid-frame restart
      send_exp(1,   1, 3, 1,   1, 3, 0);
      send_exp(2,   0, 3, 2,   1, 3, 0);
      send_exp(3,   0, 3, 3,   1, 3, 0);
      send_exp(4,   0, 3, 0,   0, 3, 0);
      send_exp(5,   0, 3, 0,   0, 3, 0);
      send_exp(100, 1, 1, 100, 1, 1, 0);
      send_exp(103, 0, 1, 3,   0, 1, 0);
      drain();

      // Order select: 7 clamps to 4; iOrder without frame start is ignored
      send_exp(0,  1, 7,   0, 1, 4, 0);
      send_exp(0,  0, 7,   0, 1, 4, 0);
      send_exp(0,  0, 7,   0, 1, 4, 0);
      send_exp(0,  0, 7,   0, 1, 4, 0);
      send_exp(16, 0, 7,  16, 0, 4, 0);
      send_exp(0,  0, 1, -64, 0, 4, 0);
      send_exp(0,  0, 2,  96, 0, 4, 0);
      drain();

      // Reset one clock after acceptance, with a frame-start sample offered
      // during reset; neither may emerge.
      drive(1234, 0, 0, dropped);
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b1;
      fs    = 1'b1;
      ord   = 3'd2;
      smp   = 16'sd555;
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b0;
      fs    = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         check("post_rst_valid", valid, 0);
         check("post_rst_data", data, 0);
         @(negedge clk);
      end
      check("post_rst_warm", warm, 0);
      check("post_rst_order", oord, 0);

      // No frame start since reset: order 0, no warm-up
      send_exp(7,  0, 3,  7, 0, 0, 0);
      send_exp(-3, 0, 5, -3, 0, 0, 0);
      send_exp(50, 1, 1, 50, 1, 1, 0);
      send_exp(52, 0, 1,  2, 0, 1, 0);
      drain();

      // Random mix against the reference model
      for (int i = 0; i < 120; i++) begin
         int x;
         bit f;
         int o;
         int g;
         x = int'($urandom_range(0, 65535)) - 32768;
         f = ($urandom_range(0, 5) == 0);
         o = int'($urandom_range(0, 7));
         g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         send_model(x, f, o, g);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fixed_encoder_multi_order.md
# fixed_encoder_multi_order

Parametrised fixed-polynomial FLAC residual encoder. It generalises the single-order, fixed-latency fixed encoders to one block with per-frame selectable order 0–4, a parametrised sample width, and full-precision residual output. It computes FLAC warm-up handling internally and adds explicit output-valid and warm-up flags. It sits between the sample source and the residual/Rice encoding stage, one instance per channel.

## Interface
- SAMPLE_WIDTH, 16, signed input sample width in bits.
- RESIDUAL_WIDTH, SAMPLE_WIDTH+4, signed output width; worst-case order-4 growth needs exactly this, so no overflow is possible.

- iClock  in  1  clock, all state changes on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  sample strobe; iSample is accepted on every clock where iEnable=1.
- iFrameStart  in  1  qualified by iEnable; marks the accepted sample as the first of a new frame.
- iOrder  in  3  predictor order, latched only on an accepted iFrameStart sample; values 5–7 latch as 4.
- iSample  in  SAMPLE_WIDTH  signed input sample.
- oData  out  RESIDUAL_WIDTH  signed residual, or the sign-extended verbatim warm-up sample.
- oValid  out  1  oData holds the result for one accepted sample.
- oWarmup  out  1  qualified by oValid; oData is a verbatim warm-up sample.
- oOrder  out  3  order used for the sample currently on oData.

## Operation
- **History.** History registers x[n-1]..x[n-4] shift only on accepted samples. Clocks with iEnable=0 leave all state untouched (bubbles).
- **Frame start.** An accepted sample with iFrameStart=1:
  - latches iOrder into the frame order;
  - clears the per-frame warm-up counter to 0;
  - that sample itself is warm-up index 0.
- **Warm-up counter.** Saturating, 0..4, incremented per accepted sample. A sample is warm-up iff counter < frame order. Order 0 has no warm-up samples.
- **Residual per order** (full precision, exact, no saturation or truncation):
  - order 0: x;
  - order 1: x − x1;
  - order 2: x − 2x1 + x2;
  - order 3: x − 3x1 + 3x2 − x3;
  - order 4: x − 4x1 + 6x2 − 4x3 + x4.
- **Warm-up output.** oData = sign-extended x, oWarmup=1.
- **No frame start since reset.** Samples accepted before the first frame start use order 0, counter saturated (no warm-up).
- **Order change.** iOrder changes without iFrameStart are ignored. A frame start may arrive on any sample, including mid-frame: warm-up restarts immediately.
- **History at frame start.** History is not cleared at frame start. Warm-up guarantees that stale history never reaches a non-warm-up residual.

## Timing
- Three-stage pipeline, free-running; iEnable bubbles propagate as oValid=0:
  - S1: register sample, frame-start flag and valid; update order/counter and history taps;
  - S2: register multiplied/partial-sum terms;
  - S3: final sum, warm-up mux, output register.
- **Latency.** A sample accepted at edge k appears on oData/oValid/oWarmup/oOrder after edge k+3, independent of order.
- **Throughput.** One sample per clock. No backpressure; downstream must accept every oValid.
- **Reset values.** oData=0, oValid=0, oWarmup=0, oOrder=0. Frame order=0, counter saturated, history=0, all pipeline valids=0.
- **Reset mid-stream.** Samples in flight are discarded: oValid=0 on the clock after reset until new samples emerge 3 clocks after their acceptance.
- **Reset and iEnable together.** Reset wins; the sample is not accepted.
- **Back-to-back frame starts.** Each one relatches the order; a 1-sample frame is entirely warm-up if order ≥ 1.

## Test plan
1. **Order 2, contiguous.** Reset, then frame start with order 2, samples 10, 20, 40, 70 → oData 10, 20, 10, 10; oWarmup 1, 1, 0, 0; first oValid 3 clocks after the first sample.
2. **Order 4 extreme.** Order 4 at SAMPLE_WIDTH=16, samples 32767, −32768, 32767, −32768, 32767 → four warm-ups, then residual 524280 with no wrap.
3. **Order 1 with bubbles.** Order 1, samples 5, 8, 4, with iEnable low for 2 clocks between each → oData 5 (warm-up), 3, −4; oValid pulses spaced identically to the input.
4. **Mid-frame restart.** Order 3 frame: 1, 2, 3, 4, 5, then frame start with iOrder=1 on sample 100, then 103 → 1, 2, 3 warm-up; 0, 0; 100 warm-up; 3; oOrder switches from 3 to 1 exactly with sample 100.
5. **Order select.** iOrder=7 at frame start → oOrder=4. Changing iOrder mid-frame without iFrameStart → no change.
6. **Reset mid-pipeline.** Reset asserted 1 clock after a sample is accepted → oValid stays 0 and outputs are 0. Order 0 is applied until the next frame start.
